fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage sitting directly upstream of the instruction interpreter. Owns the program counter and drives the instruction ROM's enable and address. Registers each fetched 16-bit word into an output instruction register and presents it to the interpreter with a valid/ready handshake. Supports a one-cycle PC redirect for branches and stops cleanly after the last program word.

## Interface
Parameters:
- ADDR_W, 4, ROM address width; PC wraps modulo 2^ADDR_W.
- INST_W, 16, instruction width.
- PROG_LEN, 9, number of program words; legal range 1..2^ADDR_W; last fetched address is PROG_LEN-1.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin fetching from address 0; sampled only in IDLE.
- mem_en  out  1  ROM read enable (combinational from state).
- mem_addr  out  ADDR_W  ROM address = current PC (combinational).
- mem_data  in  INST_W  ROM read data, combinational same-cycle return.
- inst  out  INST_W  registered instruction to the interpreter.
- inst_valid  out  1  inst holds an unconsumed instruction.
- inst_ready  in  1  interpreter accepts inst this cycle.
- redirect_valid  in  1  branch taken; flush and refetch.
- redirect_target  in  ADDR_W  new PC.
- done  out  1  registered; high once the last word has been consumed.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: mem_en=0. start=1 at an edge -> RUN, PC=0.
- RUN: mem_en=1, mem_addr=PC. A load occurs when (!inst_valid || inst_ready): inst<=mem_data, inst_valid<=1, PC<=PC+1 (mod 2^ADDR_W). If the loaded address equals PROG_LEN-1 -> DRAIN. With no load (valid && !ready), inst, inst_valid and PC hold.
- DRAIN: mem_en=0. On inst_ready with inst_valid: inst_valid<=0 and state becomes DONE, with done<=1.
- DONE: mem_en=0, done held at 1. start is ignored.
- Redirect, RUN or DRAIN: takes priority over load and handshake. Sets inst_valid<=0, discarding the held word even if inst_ready=1 in the same cycle. Sets PC<=redirect_target and state becomes RUN. No ROM word is loaded in that cycle.
- Redirect, DONE: same action, plus done<=0, which restarts fetching.
- Redirect, IDLE: ignored.
- Redirect target beyond PROG_LEN-1: fetching continues, wrapping at 2^ADDR_W, until address PROG_LEN-1 is loaded.
- Reset (asynchronous, any time, including mid-handshake): state=IDLE, PC=0, inst=0, inst_valid=0, done=0. mem_en=0 and mem_addr=0 follow combinationally.

## Timing
- Latency: start high at edge N -> RUN after N, with mem_en=1 and mem_addr=0 during cycle N..N+1. inst_valid=1 with word 0 after edge N+1.
- Throughput: one instruction per cycle while inst_ready is held high.
- Redirect at edge M -> word at target is valid after edge M+1. Exactly one bubble cycle.
- inst and inst_valid never change while inst_valid=1 and inst_ready=0, except on redirect or reset.
- done rises at the same edge that consumes the last word.

## Configuration
- FETCH_PC_TAG_EN defined: adds output inst_pc (ADDR_W). It is registered alongside inst, holds the address inst was fetched from, and resets to 0.
- FETCH_PC_TAG_EN undefined: the inst_pc port and register are absent. Behaviour is otherwise identical.

## Structure
- Shared package cool_pkg holds:
  - INST_W and ADDR_W defaults;
  - the fetch state enum typedef (IDLE, RUN, DRAIN, DONE);
  - the instruction word typedef.
- One sub-module, fetch_pc: PC register with async active-low reset, load (redirect/start) and wrap-around increment enables. The FSM and instruction register live in fetch_unit.

## Test plan
- Free-running: PROG_LEN=9, ROM[i]=0x1000+i, inst_ready=1, start pulse. Required: 9 consecutive valid words 0x1000..0x1008 on successive cycles, then done=1 and mem_en=0.
- Backpressure: hold inst_ready=0 for 3 cycles on word 2. Required: inst stays 0x1002 with inst_valid=1, and PC/mem_addr stay 3. On release, 0x1003 follows next cycle.
- Redirect: redirect_valid with target 6 while inst=0x1002 is valid and inst_ready=1. Required: 0x1002 is dropped, one bubble, then 0x1006, 0x1007, 0x1008, then done.
- Wrap: PROG_LEN=16, redirect target 15 after done. Required: done falls, word 15 is fetched, DRAIN, done rises. PC wraps to 0 without a fetch.
- Reset mid-run: assert rst_n=0 asynchronously between edges with inst_valid=1. Required: inst_valid=0, inst=0, done=0 and mem_en=0 immediately. After release, stays in IDLE until start.
- With FETCH_PC_TAG_EN: repeat the free-running case. Required: inst_pc equals 0..8 in lockstep with inst.

Source files
------------

// File: rtl/cool_pkg.sv
// Shared fetch-stage types: default widths, fetch FSM state encoding and instruction word type.
package cool_pkg;

    localparam int DEFAULT_ADDR_W = 4;
    localparam int DEFAULT_INST_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } fetch_state_t;

    typedef logic [DEFAULT_INST_W-1:0] inst_word_t;

endpackage

// File: rtl/fetch_pc.sv
// Program counter register: parallel load (start/redirect) has priority over wrap-around increment.
module fetch_pc #(
    parameter int ADDR_W = cool_pkg::DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_value,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else if (load) begin
            pc <= load_value;
        end else if (inc) begin
            pc <= pc + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads the ROM and hands words to the interpreter via valid/ready.
// Optional FETCH_PC_TAG_EN adds an inst_pc output carrying the fetch address of inst.
module fetch_unit
    import cool_pkg::*;
#(
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int INST_W   = DEFAULT_INST_W,
    parameter int PROG_LEN = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [INST_W-1:0] mem_data,
    output logic [INST_W-1:0] inst,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
`ifdef FETCH_PC_TAG_EN
    output logic [ADDR_W-1:0] inst_pc,
`endif
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PROG_LEN - 1);

    fetch_state_t      state_q;
    fetch_state_t      state_d;
    logic [ADDR_W-1:0] pc;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_load_value;
    logic              pc_inc;
    logic              load_inst;
    logic              clear_valid;
    logic              set_done;
    logic              clear_done;

    fetch_pc #(.ADDR_W(ADDR_W)) u_pc (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (pc_load),
        .load_value (pc_load_value),
        .inc        (pc_inc),
        .pc         (pc)
    );

    assign mem_addr = pc;

    // NOTE: every output of this block is defaulted first so no path leaves a latch behind.
    always_comb begin
        state_d       = state_q;
        mem_en        = 1'b0;
        pc_load       = 1'b0;
        pc_load_value = '0;
        pc_inc        = 1'b0;
        load_inst     = 1'b0;
        clear_valid   = 1'b0;
        set_done      = 1'b0;
        clear_done    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    pc_load = 1'b1;
                end
            end
            RUN: begin
                mem_en = 1'b1;
                if (!inst_valid || inst_ready) begin
                    load_inst = 1'b1;
                    pc_inc    = 1'b1;
                    if (pc == LAST_ADDR) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (inst_valid && inst_ready) begin
                    clear_valid = 1'b1;
                    set_done    = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
        endcase

        // A taken branch overrides any load or handshake decided above.
        if (redirect_valid && state_q != IDLE) begin
            state_d       = RUN;
            pc_load       = 1'b1;
            pc_load_value = redirect_target;
            pc_inc        = 1'b0;
            load_inst     = 1'b0;
            clear_valid   = 1'b1;
            set_done      = 1'b0;
            clear_done    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            inst       <= '0;
            inst_valid <= 1'b0;
            done       <= 1'b0;
`ifdef FETCH_PC_TAG_EN
            inst_pc    <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (clear_valid) begin
                inst_valid <= 1'b0;
            end else if (load_inst) begin
                inst       <= mem_data;
                inst_valid <= 1'b1;
`ifdef FETCH_PC_TAG_EN
                inst_pc    <= pc;
`endif
            end
            if (clear_done) begin
                done <= 1'b0;
            end else if (set_done) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed steps plus randomized traffic against a queue-based model.
module tb_fetch_unit;

    localparam int ADDR_W   = 4;
    localparam int INST_W   = 16;
    localparam int PROG_LEN = 9;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;

    logic              start = 1'b0;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [INST_W-1:0] mem_data;
    logic [INST_W-1:0] inst;
    logic              inst_valid;
    logic              inst_ready = 1'b0;
    logic              redirect_valid = 1'b0;
    logic [ADDR_W-1:0] redirect_target = '0;
    logic              done;
`ifdef FETCH_PC_TAG_EN
    logic [ADDR_W-1:0] inst_pc;
    logic [ADDR_W-1:0] inst_pc16;
`endif

    logic              start16 = 1'b0;
    logic              mem_en16;
    logic [ADDR_W-1:0] mem_addr16;
    logic [INST_W-1:0] mem_data16;
    logic [INST_W-1:0] inst16;
    logic              inst_valid16;
    logic              inst_ready16 = 1'b0;
    logic              redirect_valid16 = 1'b0;
    logic [ADDR_W-1:0] redirect_target16 = '0;
    logic              done16;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    assign mem_data   = 16'h1000 + 16'(mem_addr);
    assign mem_data16 = 16'h1000 + 16'(mem_addr16);

    fetch_unit #(.ADDR_W(ADDR_W), .INST_W(INST_W), .PROG_LEN(PROG_LEN)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .mem_en          (mem_en),
        .mem_addr        (mem_addr),
        .mem_data        (mem_data),
        .inst            (inst),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
`ifdef FETCH_PC_TAG_EN
        .inst_pc         (inst_pc),
`endif
        .done            (done)
    );

    fetch_unit #(.ADDR_W(ADDR_W), .INST_W(INST_W), .PROG_LEN(16)) dut16 (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start16),
        .mem_en          (mem_en16),
        .mem_addr        (mem_addr16),
        .mem_data        (mem_data16),
        .inst            (inst16),
        .inst_valid      (inst_valid16),
        .inst_ready      (inst_ready16),
        .redirect_valid  (redirect_valid16),
        .redirect_target (redirect_target16),
`ifdef FETCH_PC_TAG_EN
        .inst_pc         (inst_pc16),
`endif
        .done            (done16)
    );

    // Reference model: the list of addresses still to be fetched plus the one-word output slot.
    int          pend[$];
    bit          m_started;
    bit          m_valid;
    logic [15:0] m_inst;
    int          m_addr;
    bit          m_done;

    function automatic logic [15:0] rom_word(input int a);
        return 16'h1000 + 16'(a);
    endfunction

    task automatic model_reset();
        pend.delete();
        m_started = 0;
        m_valid   = 0;
        m_inst    = '0;
        m_addr    = 0;
        m_done    = 0;
    endtask

    task automatic fill_from(input int t);
        int a;
        pend.delete();
        a = t;
        forever begin
            pend.push_back(a);
            if (a == PROG_LEN - 1) break;
            a = (a + 1) % (1 << ADDR_W);
        end
    endtask

    task automatic model_edge(input bit s, input bit rdy, input bit rv, input int rt);
        bit consumed;
        int a;
        consumed = m_valid && rdy;
        if (!m_started) begin
            if (s) begin
                m_started = 1;
                fill_from(0);
            end
        end else if (rv) begin
            m_valid = 0;
            m_done  = 0;
            fill_from(rt);
        end else if (pend.size() > 0) begin
            if (!m_valid || rdy) begin
                a       = pend.pop_front();
                m_valid = 1;
                m_inst  = rom_word(a);
                m_addr  = a;
            end
        end else if (consumed) begin
            m_valid = 0;
            m_done  = 1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        bit exp_en;
        exp_en = m_started && (pend.size() > 0);
        check("inst_valid", inst_valid, m_valid);
        if (m_valid) check("inst", inst, m_inst);
`ifdef FETCH_PC_TAG_EN
        if (m_valid) check("inst_pc", inst_pc, m_addr);
`endif
        check("done", done, m_done);
        check("mem_en", mem_en, exp_en);
        if (exp_en) check("mem_addr", mem_addr, pend[0]);
    endtask

    task automatic step(input bit s, input bit rdy, input bit rv, input int rt);
        start           = s;
        inst_ready      = rdy;
        redirect_valid  = rv;
        redirect_target = ADDR_W'(rt);
        model_edge(s, rdy, rv, rt);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic edge16();
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();

        // Reset state
        #2;
        check("rst_valid", inst_valid, 1'b0);
        check("rst_inst", inst, 16'h0);
        check("rst_done", done, 1'b0);
        check("rst_mem_en", mem_en, 1'b0);
        check("rst_mem_addr", mem_addr, 4'h0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(0, 1, 1, 3);
        check("idle_ignores_redirect", mem_en, 1'b0);

        // Free-running program
        step(1, 1, 0, 0);
        check("fr_first_addr", mem_addr, 4'h0);
        for (int i = 0; i < PROG_LEN; i++) begin
            step(0, 1, 0, 0);
            check("fr_word", inst, 16'h1000 + 16'(i));
        end
        step(0, 1, 0, 0);
        check("fr_done", done, 1'b1);
        check("fr_mem_en", mem_en, 1'b0);
        step(1, 1, 0, 0);
        check("done_ignores_start", mem_en, 1'b0);

        // Backpressure on word 2 (restart from DONE via redirect)
        step(0, 1, 1, 0);
        check("restart_done_low", done, 1'b0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
        check("bp_word2", inst, 16'h1002);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0);
            check("bp_hold_inst", inst, 16'h1002);
            check("bp_hold_addr", mem_addr, 4'h3);
        end
        step(0, 1, 0, 0);
        check("bp_release", inst, 16'h1003);

        // Redirect while 0x1002 is valid and being accepted
        step(0, 1, 1, 2);
        step(0, 1, 0, 0);
        check("rd_setup", inst, 16'h1002);
        step(0, 1, 1, 6);
        check("rd_bubble", inst_valid, 1'b0);
        for (int i = 6; i < PROG_LEN; i++) begin
            step(0, 1, 0, 0);
            check("rd_word", inst, 16'h1000 + 16'(i));
        end
        step(0, 1, 0, 0);
        check("rd_done", done, 1'b1);

        // Randomized traffic
        for (int n = 0; n < 500; n++) begin
            bit rdy;
            bit rv;
            rdy = ($urandom_range(0, 9) < 7);
            rv  = m_done ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 24) == 0);
            step(bit'($urandom_range(0, 1)), rdy, rv, int'($urandom_range(0, 15)));
        end

        // Asynchronous reset mid-run with a valid word held
        step(0, 1, 1, 0);
        step(0, 0, 0, 0);
        check("mr_valid_before", inst_valid, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check("mr_valid", inst_valid, 1'b0);
        check("mr_inst", inst, 16'h0);
        check("mr_done", done, 1'b0);
        check("mr_mem_en", mem_en, 1'b0);
        check("mr_mem_addr", mem_addr, 4'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(0, 1, 1, 5);
        check("mr_stays_idle", mem_en, 1'b0);
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        check("mr_restart", inst, 16'h1000);

        // PROG_LEN=16 instance: wrap after the final word
        inst_ready16 = 1'b1;
        start16 = 1'b1;
        edge16();
        start16 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            edge16();
            check("w_word", inst16, 16'h1000 + 16'(i));
        end
        edge16();
        check("w_done", done16, 1'b1);
        check("w_mem_en_done", mem_en16, 1'b0);
        redirect_valid16  = 1'b1;
        redirect_target16 = 4'hF;
        edge16();
        redirect_valid16 = 1'b0;
        check("w_done_fall", done16, 1'b0);
        check("w_bubble", inst_valid16, 1'b0);
        check("w_mem_en_run", mem_en16, 1'b1);
        check("w_addr15", mem_addr16, 4'hF);
        edge16();
        check("w_word15", inst16, 16'h100F);
        check("w_valid15", inst_valid16, 1'b1);
        check("w_drain_en", mem_en16, 1'b0);
        check("w_pc_wrap", mem_addr16, 4'h0);
        check("w_done_still_low", done16, 1'b0);
        edge16();
        check("w_done_rise", done16, 1'b1);
        check("w_valid_clear", inst_valid16, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
